// File: rtl/lvdc_clock_pkg.sv
// Shared types and constants for the four-phase master clock generator.
// Phase lines are carried as a packed (P,Q,R) triple; complements are
// derived at the output registers.
package lvdc_clock_pkg;

  typedef enum logic [1:0] {
    PH_W = 2'd0,
    PH_X = 2'd1,
    PH_Y = 2'd2,
    PH_Z = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2,
    STEP   = 2'd3
  } gen_state_t;

  typedef struct packed {
    logic p;
    logic q;
    logic r;
  } pqr_t;

  localparam pqr_t PQR_W = '{p: 1'b1, q: 1'b1, r: 1'b1};
  localparam pqr_t PQR_X = '{p: 1'b0, q: 1'b1, r: 1'b0};
  localparam pqr_t PQR_Y = '{p: 1'b1, q: 1'b0, r: 1'b0};
  localparam pqr_t PQR_Z = '{p: 1'b0, q: 1'b0, r: 1'b1};

  // Phase-line pattern presented to the drivers for a given phase.
  function automatic pqr_t phase_pqr(input phase_t ph);
    case (ph)
      PH_W:    return PQR_W;
      PH_X:    return PQR_X;
      PH_Y:    return PQR_Y;
      default: return PQR_Z;
    endcase
  endfunction

  // W -> X -> Y -> Z -> W; the 2-bit encoding wraps naturally.
  function automatic phase_t next_phase(input phase_t ph);
    return phase_t'(ph + 2'd1);
  endfunction

endpackage

// File: rtl/clock_divider.sv
// DIV-cycle tick generator. tick is high on the last cycle of each
// DIV-cycle slot while enabled; clr restarts the slot synchronously.
module clock_divider
  import lvdc_clock_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  logic [3:0] cnt_q;

  assign tick = en && (cnt_q == DIV_LAST);

  // Slot counter: clear wins, otherwise count 0..DIV-1 while enabled.
  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? 4'd0 : cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/clock_generator.sv
// Master clock-phase generator: divides clk into a repeating W-X-Y-Z
// sequence on the P/Q/R phase lines, gates the drivers with bop, counts
// bit times within a word and supports halting at bit boundaries.
// Optional single-step support is built when CLOCK_GEN_STEP_EN is defined;
// otherwise step_req is ignored and step_ack is tied low.
//
// Every entry into RUN or STEP starts with a lead-in slot of DIV cycles
// holding Z; the Z->W advance that ends the lead-in is not a bit boundary,
// because the bit counter was already updated when the previous bit ended.
module clock_generator
  import lvdc_clock_pkg::*;
#(
  parameter int DIV           = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int WORD_BITS     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt_req,
  input  logic       step_req,
  output logic       cgpp,
  output logic       cgppn,
  output logic       cgqp,
  output logic       cgqpn,
  output logic       cgrp,
  output logic       cgrpn,
  output logic       bop,
  output logic [4:0] bit_cnt,
  output logic       word_end,
  output logic       halted,
  output logic       step_ack
);

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [4:0] BIT_LAST    = 5'(WORD_BITS - 1);

  gen_state_t state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] settle_cnt_q;
  logic       lead_q, lead_d;
  logic       tick, div_en, div_clr, boundary, step_go, wrap;
  pqr_t       pqr_d;

  logic cgpp_q, cgppn_q, cgqp_q, cgqpn_q, cgrp_q, cgrpn_q;
  logic bop_q, word_end_q, halted_q;

`ifdef CLOCK_GEN_STEP_EN
  logic step_ack_q;
  assign step_go = step_req;
`else
  logic unused_step_req;
  assign unused_step_req = step_req;
  assign step_go         = 1'b0;
`endif

  clock_divider #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  // Next state, phase, bit count and lead-in flag.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    lead_d    = lead_q;
    wrap      = 1'b0;
    div_en    = (state_q == RUN) || (state_q == STEP);
    boundary  = div_en && tick && !lead_q && (phase_q == PH_Z);

    case (state_q)
      SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = RUN;
      RUN:    if (boundary && halt_req) state_d = HALT;
      HALT: begin
        if (!halt_req)    state_d = RUN;
        else if (step_go) state_d = STEP;
      end
`ifdef CLOCK_GEN_STEP_EN
      STEP:   if (boundary) state_d = HALT;
`endif
      default: state_d = SETTLE;
    endcase

    if (div_en && tick) begin
      lead_d = 1'b0;
      if (boundary) begin
        wrap      = (bit_cnt_q == BIT_LAST);
        bit_cnt_d = wrap ? 5'd0 : bit_cnt_q + 5'd1;
        phase_d   = (state_d == HALT) ? PH_Z : PH_W;
      end else begin
        phase_d = next_phase(phase_q);
      end
    end

    if ((state_d != state_q) && ((state_d == RUN) || (state_d == STEP))) lead_d = 1'b1;

    div_clr = (state_d != state_q);
    pqr_d   = phase_pqr(phase_d);
  end

  // FSM, counters and registered outputs; reset is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      phase_q      <= PH_Z;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      lead_q       <= 1'b0;
      cgpp_q       <= PQR_Z.p;
      cgppn_q      <= ~PQR_Z.p;
      cgqp_q       <= PQR_Z.q;
      cgqpn_q      <= ~PQR_Z.q;
      cgrp_q       <= PQR_Z.r;
      cgrpn_q      <= ~PQR_Z.r;
      bop_q        <= 1'b0;
      word_end_q   <= 1'b0;
      halted_q     <= 1'b0;
`ifdef CLOCK_GEN_STEP_EN
      step_ack_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      lead_q     <= lead_d;
      if (state_q == SETTLE) settle_cnt_q <= settle_cnt_q + 10'd1;
      cgpp_q     <= pqr_d.p;
      cgppn_q    <= ~pqr_d.p;
      cgqp_q     <= pqr_d.q;
      cgqpn_q    <= ~pqr_d.q;
      cgrp_q     <= pqr_d.r;
      cgrpn_q    <= ~pqr_d.r;
      bop_q      <= (state_d == RUN) || (state_d == STEP);
      word_end_q <= wrap;
      halted_q   <= (state_d == HALT);
`ifdef CLOCK_GEN_STEP_EN
      step_ack_q <= boundary && (state_q == STEP);
`endif
    end
  end

  assign cgpp     = cgpp_q;
  assign cgppn    = cgppn_q;
  assign cgqp     = cgqp_q;
  assign cgqpn    = cgqpn_q;
  assign cgrp     = cgrp_q;
  assign cgrpn    = cgrpn_q;
  assign bop      = bop_q;
  assign bit_cnt  = bit_cnt_q;
  assign word_end = word_end_q;
  assign halted   = halted_q;
`ifdef CLOCK_GEN_STEP_EN
  assign step_ack = step_ack_q;
`else
  assign step_ack = 1'b0;
`endif

endmodule
